// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding for the switch debouncer
package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'b00,
    WAIT1 = 2'b01,
    ONE   = 2'b10,
    WAIT0 = 2'b11
  } state_e;

  // Level seen downstream: high once a 1 is accepted, until a 0 is accepted.
  function automatic logic level_of(state_e s);
    return (s == ONE) || (s == WAIT0);
  endfunction

endpackage

// File: rtl/debounce_if.sv
// rtl/debounce_if.sv - raw switch in, debounced level and rise pulse out
interface debounce_if;
  logic sw;
  logic db_level;
  logic db_tick;

  modport master (output sw, input db_level, input db_tick);
  modport slave  (input sw, output db_level, output db_tick);
endinterface

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running sample timer, one-cycle tick per period
module sample_tick_gen #(
  parameter int TICK_DIV = 200000
) (
  input  logic clk,
  input  logic reset,
  output logic m_tick
);

  localparam int             TW     = $clog2(TICK_DIV);
  localparam logic [TW-1:0]  T_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  T_ONE  = TW'(1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  assign m_tick  = (timer_q == T_LAST);
  assign timer_d = m_tick ? '0 : timer_q + T_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) timer_q <= '0;
    else       timer_q <= timer_d;
  end

endmodule

// File: rtl/debounce_fsm.sv
// rtl/debounce_fsm.sv - synchronise a bouncing switch and accept a new level
// only after STABLE_SAMPLES consecutive agreeing sample ticks
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int TICK_DIV       = 200000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic     clk,
  input  logic     reset,
  debounce_if.slave db
);

  localparam int              CW       = $clog2(STABLE_SAMPLES + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(STABLE_SAMPLES);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  logic          s1_q, sw_s_q;
  logic          m_tick;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_level_q, db_tick_q, db_tick_d;

  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .m_tick (m_tick)
  );

  // A disagreeing synchronised sample aborts a wait before any tick is counted.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    db_tick_d = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw_s_q) begin
          state_d = WAIT1;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT1: begin
        if (!sw_s_q) begin
          state_d = ZERO;
        end else if (m_tick) begin
          if (cnt_q == CNT_ONE) begin
            state_d   = ONE;
            db_tick_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ONE: begin
        if (!sw_s_q) begin
          state_d = WAIT0;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT0: begin
        if (sw_s_q) begin
          state_d = ONE;
        end else if (m_tick) begin
          if (cnt_q == CNT_ONE) state_d = ZERO;
          else                  cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ZERO;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= 1'b0;
      sw_s_q     <= 1'b0;
      state_q    <= ZERO;
      cnt_q      <= '0;
      db_level_q <= 1'b0;
      db_tick_q  <= 1'b0;
    end else begin
      s1_q       <= db.sw;
      sw_s_q     <= s1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      db_level_q <= level_of(state_d);
      db_tick_q  <= db_tick_d;
    end
  end

  assign db.db_level = db_level_q;
  assign db.db_tick  = db_tick_q;

endmodule
